// File: rtl/acc_reg_bank.sv
// Multi-channel accumulator register bank: per-channel load/add/sub with optional saturation,
// sticky overflow and beat counting; a last beat emits the result and auto-clears the channel.
module acc_reg_bank #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CH    = 4,
  parameter int unsigned SAT   = 1,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned CW   = $clog2(CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_ch,
  input  logic [1:0]       in_op,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_ch,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  input  logic [CW-1:0]    rd_ch,
  output logic [ACC_W-1:0] rd_data
);

  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  logic [ACC_W-1:0] acc [CH];
  logic [CNT_W-1:0] cnt [CH];
  logic [CH-1:0]    ovf;

  logic             accept;
  logic [ACC_W-1:0] cur_acc, nxt_acc;
  logic [CNT_W-1:0] cur_cnt, nxt_cnt;
  logic             cur_ovf, nxt_ovf;
  logic [ACC_W:0]   opnd, sum_w, dif_w;

  // A pending result that is not being taken stalls the input side
  assign in_ready = !clr && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign rd_data  = acc[rd_ch];

  // Next value of the addressed channel for the current beat
  always_comb begin
    cur_acc = acc[in_ch];
    cur_cnt = cnt[in_ch];
    cur_ovf = ovf[in_ch];
    opnd    = (ACC_W+1)'(in_data);
    sum_w   = {1'b0, cur_acc} + opnd;
    dif_w   = {1'b0, cur_acc} - opnd;
    nxt_acc = cur_acc;
    nxt_ovf = cur_ovf;
    nxt_cnt = (cur_cnt == {CNT_W{1'b1}}) ? cur_cnt : cur_cnt + CNT_W'(1);
    case (in_op)
      OP_LOAD: begin
        nxt_acc = ACC_W'(in_data);
        nxt_cnt = CNT_W'(1);
        nxt_ovf = 1'b0;
      end
      OP_ADD: begin
        nxt_acc = sum_w[ACC_W-1:0];
        if (sum_w[ACC_W]) begin
          nxt_ovf = 1'b1;
          if (SAT != 0) nxt_acc = '1;
        end
      end
      OP_SUB: begin
        nxt_acc = dif_w[ACC_W-1:0];
        if (dif_w[ACC_W]) begin
          nxt_ovf = 1'b1;
          if (SAT != 0) nxt_acc = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
      ovf       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (clr) begin
        for (int unsigned i = 0; i < CH; i++) begin
          acc[i] <= '0;
          cnt[i] <= '0;
        end
        ovf <= '0;
      end else if (accept) begin
        if (in_last) begin
          // Result goes to the output register; the channel restarts from zero
          acc[in_ch] <= '0;
          cnt[in_ch] <= '0;
          ovf[in_ch] <= 1'b0;
          out_valid  <= 1'b1;
          out_ch     <= in_ch;
          out_data   <= nxt_acc;
          out_count  <= nxt_cnt;
          out_ovf    <= nxt_ovf;
        end else begin
          acc[in_ch] <= nxt_acc;
          cnt[in_ch] <= nxt_cnt;
          ovf[in_ch] <= nxt_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_reg_bank.sv
// Bench for acc_reg_bank: saturating and wrapping instances driven in parallel,
// checked against a behavioural model with a result queue.
module tb_acc_reg_bank;

  localparam int CH = 4;
  localparam longint MAXV = 65535;
  localparam int CMAX = 255;

  logic clk = 1'b0;
  logic rst, clr, in_valid, in_last, out_ready;
  logic [1:0] in_ch, in_op, rd_ch;
  logic [7:0] in_data;

  logic        in_ready_s, out_valid_s, out_ovf_s;
  logic [1:0]  out_ch_s;
  logic [15:0] out_data_s, rd_data_s;
  logic [7:0]  out_count_s;
  logic        in_ready_w, out_valid_w, out_ovf_w;
  logic [1:0]  out_ch_w;
  logic [15:0] out_data_w, rd_data_w;
  logic [7:0]  out_count_w;

  acc_reg_bank #(.IN_W(8), .ACC_W(16), .CH(4), .SAT(1), .CNT_W(8)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_ch(in_ch), .in_op(in_op), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_ch(out_ch_s),
    .out_data(out_data_s), .out_count(out_count_s), .out_ovf(out_ovf_s),
    .rd_ch(rd_ch), .rd_data(rd_data_s));

  acc_reg_bank #(.IN_W(8), .ACC_W(16), .CH(4), .SAT(0), .CNT_W(8)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_ch(in_ch), .in_op(in_op), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_ch(out_ch_w),
    .out_data(out_data_w), .out_count(out_count_w), .out_ovf(out_ovf_w),
    .rd_ch(rd_ch), .rd_data(rd_data_w));

  always #5 clk = ~clk;

  typedef struct {
    int     ch;
    longint ds;
    longint dw;
    int     cnt;
    bit     os;
    bit     ow;
  } res_t;

  res_t   q[$];
  longint ma_s[CH], ma_w[CH];
  int     mcnt[CH];
  bit     mo_s[CH], mo_w[CH];
  int     ntests = 0;
  int     nfail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < CH; i++) begin
      ma_s[i] = 0; ma_w[i] = 0; mcnt[i] = 0; mo_s[i] = 0; mo_w[i] = 0;
    end
  endtask

  // One clock: check in_ready, advance the model, then check the output port
  task automatic tick();
    bit exp_rdy, acc_b, hs;
    int c, ncnt;
    longint s, ns, nw;
    bit os, ow;
    res_t r;
    #1;
    exp_rdy = !clr && (q.size() == 0 || out_ready);
    chk("in_ready_s", in_ready_s, exp_rdy);
    chk("in_ready_w", in_ready_w, exp_rdy);
    acc_b = in_valid && exp_rdy;
    hs = (q.size() != 0) && out_ready;
    @(posedge clk);
    #1;
    if (hs) void'(q.pop_front());
    if (clr) clear_model();
    else if (acc_b) begin
      c = int'(in_ch);
      ns = ma_s[c]; nw = ma_w[c]; os = mo_s[c]; ow = mo_w[c];
      ncnt = (mcnt[c] < CMAX) ? mcnt[c] + 1 : CMAX;
      case (in_op)
        2'b01: begin ns = in_data; nw = in_data; ncnt = 1; os = 0; ow = 0; end
        2'b10: begin
          s = ma_s[c] + in_data;
          if (s > MAXV) begin ns = MAXV; os = 1; end else ns = s;
          s = ma_w[c] + in_data;
          if (s > MAXV) begin nw = s - (MAXV + 1); ow = 1; end else nw = s;
        end
        2'b11: begin
          s = ma_s[c] - in_data;
          if (s < 0) begin ns = 0; os = 1; end else ns = s;
          s = ma_w[c] - in_data;
          if (s < 0) begin nw = s + MAXV + 1; ow = 1; end else nw = s;
        end
        default: ;
      endcase
      if (in_last) begin
        r.ch = c; r.ds = ns; r.dw = nw; r.cnt = ncnt; r.os = os; r.ow = ow;
        q.push_back(r);
        ma_s[c] = 0; ma_w[c] = 0; mcnt[c] = 0; mo_s[c] = 0; mo_w[c] = 0;
      end else begin
        ma_s[c] = ns; ma_w[c] = nw; mcnt[c] = ncnt; mo_s[c] = os; mo_w[c] = ow;
      end
    end
    chk("out_valid_s", out_valid_s, q.size() != 0);
    chk("out_valid_w", out_valid_w, q.size() != 0);
    if (q.size() != 0) begin
      r = q[0];
      chk("out_ch_s", out_ch_s, r.ch);
      chk("out_ch_w", out_ch_w, r.ch);
      chk("out_data_s", out_data_s, r.ds);
      chk("out_data_w", out_data_w, r.dw);
      chk("out_count_s", out_count_s, r.cnt);
      chk("out_count_w", out_count_w, r.cnt);
      chk("out_ovf_s", out_ovf_s, r.os);
      chk("out_ovf_w", out_ovf_w, r.ow);
    end
  endtask

  task automatic drive(input bit v, input int ch, input int op, input int d, input bit last);
    in_valid = v; in_ch = 2'(ch); in_op = 2'(op); in_data = 8'(d); in_last = last;
    tick();
  endtask

  task automatic chk_rd(input int ch);
    rd_ch = 2'(ch);
    #1;
    chk("rd_data_s", rd_data_s, ma_s[ch]);
    chk("rd_data_w", rd_data_w, ma_w[ch]);
  endtask

  task automatic chk_out_zero();
    chk("rst_out_valid_s", out_valid_s, 0);
    chk("rst_out_valid_w", out_valid_w, 0);
    chk("rst_out_data_s", out_data_s, 0);
    chk("rst_out_data_w", out_data_w, 0);
    chk("rst_out_ch_s", out_ch_s, 0);
    chk("rst_out_count_s", out_count_s, 0);
    chk("rst_out_ovf_s", out_ovf_s, 0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_ch = '0; in_op = '0; in_data = '0; rd_ch = '0;
    clear_model();
    #12;
    chk_out_zero();
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++) chk_rd(i);

    // Basic sequence on channel 2
    drive(1, 2, 1, 200, 0);
    drive(1, 2, 2, 100, 0);
    drive(1, 2, 3, 50, 0);
    drive(1, 2, 2, 5, 1);
    chk("seq_data", out_data_s, 255);
    chk("seq_count", out_count_s, 4);
    chk_rd(2);
    drive(0, 0, 0, 0, 0);

    // Saturation vs wrap with count saturation
    drive(1, 0, 1, 255, 0);
    for (int i = 0; i < 300; i++) drive(1, 0, 2, 255, 0);
    chk_rd(0);
    chk("sat_acc", rd_data_s, 65535);
    chk("wrap_acc", rd_data_w, 11219);
    drive(1, 0, 0, 0, 1);
    chk("sat_count", out_count_s, 255);
    chk("sat_ovf", out_ovf_s, 1);
    drive(0, 0, 0, 0, 0);

    // Underflow
    drive(1, 0, 1, 3, 0);
    drive(1, 0, 3, 10, 1);
    chk("under_sat", out_data_s, 0);
    chk("under_wrap", out_data_w, 65529);
    chk("under_ovf", out_ovf_w, 1);
    drive(0, 0, 0, 0, 0);

    // Backpressure then pass-through replace
    drive(1, 1, 1, 40, 0);
    out_ready = 1'b0;
    drive(1, 3, 1, 7, 1);
    for (int i = 0; i < 5; i++) drive(1, 1, 2, 9, 1);
    out_ready = 1'b1;
    drive(1, 1, 2, 9, 1);
    chk("replace_data", out_data_s, 49);
    chk("replace_ch", out_ch_s, 1);
    drive(0, 0, 0, 0, 0);

    // Interleaved channels, then clr with and without a pending result
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 2, 10 + i, 0);
      drive(1, 3, 2, 20 + i, 0);
    end
    chk_rd(0);
    chk_rd(3);
    clr = 1'b1;
    drive(1, 2, 1, 99, 0);
    clr = 1'b0;
    for (int i = 0; i < CH; i++) chk_rd(i);
    drive(1, 3, 1, 5, 0);
    out_ready = 1'b0;
    drive(1, 0, 1, 6, 1);
    clr = 1'b1;
    drive(1, 3, 2, 1, 0);
    clr = 1'b0;
    chk_rd(3);
    chk("clr_pending", out_data_s, 6);
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0);

    // Asynchronous reset with a pending result
    out_ready = 1'b0;
    drive(1, 1, 1, 33, 0);
    drive(1, 2, 1, 44, 1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_out_zero();
    clear_model();
    q.delete();
    chk_rd(1);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1, 1, 1, 77, 1);
    chk("post_rst_data", out_data_s, 77);
    drive(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/acc_reg_bank.md
# acc_reg_bank

Parametrised multi-channel accumulator register bank, the successor to the fixed-width 8-bit operand and 16-bit sum registers. It holds CH independent ACC_W-bit accumulators and applies one load/add/subtract operation per accepted input beat. On a beat marked last it emits the channel's final value through a valid/ready result port and auto-clears the channel. It sits between the datapath operand source and the result consumer in the arithmetic unit.

## Interface
- IN_W, 8, operand width; unsigned, zero-extended to ACC_W
- ACC_W, 16, accumulator width; must be ≥ IN_W
- CH, 4, number of channels; must be ≥ 2
- SAT, 1, 1 = saturate on overflow/underflow, 0 = wrap
- CNT_W, 8, beat-counter width per channel
- CW: derived constant, $clog2(CH)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset: asynchronous, active-high
- clr  in  1  synchronous clear of all channels, counters and ovf flags
- in_valid  in  1  operand beat valid
- in_ready  out  1  bank accepts the beat this cycle
- in_ch  in  CW  target channel
- in_op  in  2  00 hold, 01 load, 10 add, 11 sub
- in_data  in  IN_W  operand
- in_last  in  1  final beat of the channel's sequence
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes the result
- out_ch  out  CW  channel of the result
- out_data  out  ACC_W  final accumulator value
- out_count  out  CNT_W  beats accepted for that sequence, including the last
- out_ovf  out  1  sticky overflow flag of that sequence
- rd_ch  in  CW  debug read select
- rd_data  out  ACC_W  combinational value of acc[rd_ch]

## Operation
- Accept = in_valid & in_ready; in_ready = !clr & (!out_valid | out_ready).
- Load: acc ← zext(in_data); count ← 1; ovf ← 0.
- Add: wide sum = acc + zext(in_data). On carry out of ACC_W: SAT=1 gives all-ones, SAT=0 wraps mod 2^ACC_W. ovf sets.
- Sub: wide difference = acc − zext(in_data). On borrow: SAT=1 gives 0, SAT=0 wraps. ovf sets.
- Hold: acc unchanged; the beat still counts.
- count increments on every accepted non-load beat and saturates at 2^CNT_W−1.
- ovf is sticky per channel until load, last, clr or rst.
- Accepted beat with in_last:
  - The updated value, count and ovf load into the output register; out_valid ← 1.
  - The channel acc, count and ovf clear to 0 on the same edge.
- Output register holds stable while out_valid & !out_ready. It is released on the out_valid & out_ready edge.
- A non-last accept on one channel never affects the other channels.
- clr has priority over any beat: in_ready is low while clr is asserted, so no beat is accepted. clr does not disturb a pending output.

## Timing
- Reset values: every acc = 0, count = 0, ovf = 0; out_valid = 0, out_data = 0, out_ch = 0, out_count = 0, out_ovf = 0.
- in_ready is 1 after reset when clr = 0.
- Update latency: an accepted beat is visible on rd_data one cycle later.
- Last-beat latency: out_valid rises on the edge that accepts the last beat.
- Back-to-back throughput is one beat per cycle, including a last beat while out_valid & out_ready (pass-through replace).
- Stall: out_valid & !out_ready forces in_ready low; upstream must hold its beat.
- rst mid-sequence or while out_valid is set: everything returns to reset values asynchronously, and the pending result is lost.

## Test plan
- Sequence on ch 2: load 200, add 100, sub 50, add 5 (last) → out_valid next cycle, out_ch = 2, out_data = 255, out_count = 4, out_ovf = 0; rd_data for ch 2 then reads 0.
- Saturation, ACC_W = 16, SAT = 1, ch 0: load 255, then 300 add 255 beats → acc pins at 65535; ovf = 1. Same test with SAT = 0 → value wraps modulo 65536.
- Underflow: load 3, sub 10 (last) → out_data = 0 (SAT = 1) or 65529 (SAT = 0); out_ovf = 1.
- Backpressure: out_ready = 0 after a last beat → in_ready = 0 and output stable for 5 cycles. Raise out_ready together with a new last beat on ch 1 → the new result replaces the old in the same cycle with no beat lost.
- Interleave ch 0 and ch 3 adds each cycle, then clr pulse with in_valid high → in_ready = 0 that cycle; all channels read 0; pending output unaffected.
- Assert rst mid-sequence with out_valid = 1 → all outputs at reset values immediately; first beat after release is accepted.
